axi_cdc_drain_ctrl: RTL and testbench
=====================================

Name: axi_cdc_drain_ctrl

Overview:
- Sequencing controller on the synchronous side of an AXI CDC crossing, i.e. in front of the source half or behind the destination half.
- Gates the AW/AR/W handshakes and tracks outstanding write and read transactions.
- On request, it stops new transactions, drains all in-flight ones through the FIFOs, then reports the crossing as isolated. The far clock domain may then be gated or reset safely.
- Operates on valid/ready/last handshake signals only. Payload buses bypass the block.

Parameters:
- MaxTxns, 16, maximum outstanding transactions per direction (writes, reads). Must be ≥1.
- CntWidth, $clog2(MaxTxns+1), width of outstanding counters (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- isolate_req_i  in  1  level request to isolate; deassert to resume
- isolated_o  out  1  crossing drained and blocked
- slv_aw_valid_i / slv_aw_ready_o  in/out  1  upstream AW handshake
- mst_aw_valid_o / mst_aw_ready_i  out/in  1  toward CDC AW
- slv_w_valid_i, slv_w_last_i / slv_w_ready_o  in/out  1  upstream W
- mst_w_valid_o / mst_w_ready_i  out/in  1  toward CDC W
- slv_ar_valid_i / slv_ar_ready_o  in/out  1  upstream AR
- mst_ar_valid_o / mst_ar_ready_i  out/in  1  toward CDC AR
- mst_b_valid_i, mst_b_ready_i  in  1  observed B handshake (not gated)
- mst_r_valid_i, mst_r_ready_i, mst_r_last_i  in  1  observed R handshake (not gated)
- wr_outstanding_o  out  CntWidth  AW accepted, B not yet seen
- rd_outstanding_o  out  CntWidth  AR accepted, last R not yet seen
- proto_err_o  out  1  sticky flag: B or R-last seen with counter at 0

Behaviour:
- Reset (rst_i=1 at clk edge): state RUN, all counters 0, isolated_o=0, proto_err_o=0. Reset overrides any state, including mid-drain.
- Gating is purely combinational from registered state and counters, with no added latency:
  - mst_X_valid_o = slv_X_valid_i & X_en
  - slv_X_ready_o = mst_X_ready_i & X_en
  - No valid depends on a ready.
- Handshake events:
  - aw_hs = mst_aw_valid_o & mst_aw_ready_i
  - wl_hs = W handshake & slv_w_last_i
  - b_hs = mst_b_valid_i & mst_b_ready_i
  - ar_hs = AR handshake
  - rl_hs = R handshake & mst_r_last_i
- wr_cnt: +1 on aw_hs, -1 on b_hs; both in the same cycle leaves it unchanged. rd_cnt is handled the same way with ar_hs / rl_hs.
- Decrement with counter at 0 (and no simultaneous increment): counter stays 0 and proto_err_o is set.
- w_bal (signed, CntWidth+1 bits): +1 on aw_hs, -1 on wl_hs. Positive means W bursts owed; negative means W bursts led their AW.
- States:
  - RUN:
    - aw_en = (wr_cnt < MaxTxns)
    - ar_en = (rd_cnt < MaxTxns)
    - w_en = 1
    - Go to DRAIN when isolate_req_i=1.
  - DRAIN:
    - ar_en = 0
    - aw_en = (w_bal < 0) & (wr_cnt < MaxTxns). This only admits AWs matching W bursts already sent.
    - w_en = (w_bal > 0)
    - If isolate_req_i=0: go to RUN (abort).
    - Else if wr_cnt=0, rd_cnt=0 and w_bal=0: go to ISOLATED.
  - ISOLATED:
    - aw_en = w_en = ar_en = 0
    - isolated_o=1 (registered; asserted the cycle after the DRAIN exit condition holds)
    - Go to RUN when isolate_req_i=0; isolated_o drops in that same cycle as the state update.
- A handshake in the same cycle that gating closes still counts. Gating uses registered values, so no handshake is ever lost.
- The counter limit MaxTxns is enforced in every state: a saturated counter stalls AW/AR until a B/R-last arrives.
- wr_outstanding_o / rd_outstanding_o are the registered counters.

Test Plan:
- Reset with isolate_req_i=0: counters 0, isolated_o=0, all valids pass through. Then 3 AW, 3 W-last, 3 B → wr_outstanding_o goes 1,2,3 then back to 0.
- 2 writes outstanding, isolate_req_i=1: a new AW and AR are held (slv ready 0, mst valid 0) while 2 pending W bursts pass. After 2 B, isolated_o=1 exactly one cycle after wr_cnt reaches 0.
- In RUN, a W burst leads its AW (w_bal=-1), then isolate_req_i=1: the AW is still accepted in DRAIN, then B arrives, then ISOLATED. A second unmatched AW stays blocked.
- MaxTxns=2, 3 back-to-back ARs with the R bus stalled: the third AR is stalled until an R-last, then accepted the next cycle.
- aw_hs and b_hs in the same cycle at wr_cnt=1: wr_cnt stays 1. A B with wr_cnt=0 sets proto_err_o and the counter stays 0.
- Reset asserted in DRAIN with rd_cnt=2: next cycle state RUN, counters 0, AR gating reopened. Deasserting isolate_req_i in ISOLATED → RUN, isolated_o=0.

Source files
------------

// File: rtl/axi_cdc_drain_ctrl_if.sv
// Valid/ready/last handshake bundle around the CDC drain controller.
// Payload buses bypass this block and are not part of the bundle.
interface axi_cdc_drain_ctrl_if;
  logic slv_aw_valid_i;
  logic slv_aw_ready_o;
  logic mst_aw_valid_o;
  logic mst_aw_ready_i;
  logic slv_w_valid_i;
  logic slv_w_last_i;
  logic slv_w_ready_o;
  logic mst_w_valid_o;
  logic mst_w_ready_i;
  logic slv_ar_valid_i;
  logic slv_ar_ready_o;
  logic mst_ar_valid_o;
  logic mst_ar_ready_i;
  logic mst_b_valid_i;
  logic mst_b_ready_i;
  logic mst_r_valid_i;
  logic mst_r_ready_i;
  logic mst_r_last_i;

  modport slave (
    input  slv_aw_valid_i,
    output slv_aw_ready_o,
    output mst_aw_valid_o,
    input  mst_aw_ready_i,
    input  slv_w_valid_i,
    input  slv_w_last_i,
    output slv_w_ready_o,
    output mst_w_valid_o,
    input  mst_w_ready_i,
    input  slv_ar_valid_i,
    output slv_ar_ready_o,
    output mst_ar_valid_o,
    input  mst_ar_ready_i,
    input  mst_b_valid_i,
    input  mst_b_ready_i,
    input  mst_r_valid_i,
    input  mst_r_ready_i,
    input  mst_r_last_i
  );

  modport master (
    output slv_aw_valid_i,
    input  slv_aw_ready_o,
    input  mst_aw_valid_o,
    output mst_aw_ready_i,
    output slv_w_valid_i,
    output slv_w_last_i,
    input  slv_w_ready_o,
    input  mst_w_valid_o,
    output mst_w_ready_i,
    output slv_ar_valid_i,
    input  slv_ar_ready_o,
    input  mst_ar_valid_o,
    output mst_ar_ready_i,
    output mst_b_valid_i,
    output mst_b_ready_i,
    output mst_r_valid_i,
    output mst_r_ready_i,
    output mst_r_last_i
  );
endinterface

// File: rtl/axi_cdc_drain_ctrl.sv
// AXI CDC drain controller: gates AW/W/AR, counts outstanding
// transactions, drains the crossing and reports it isolated.
module axi_cdc_drain_ctrl #(
  parameter int MaxTxns  = 16,
  parameter int CntWidth = $clog2(MaxTxns + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                isolate_req_i,
  output logic                isolated_o,
  axi_cdc_drain_ctrl_if.slave bus,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic                proto_err_o
);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StIsolated
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth:0]   BalOne = (CntWidth + 1)'(1);

  state_e state_q, state_d;
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  // two's complement: +ve = W bursts owed, -ve = W led its AW
  logic [CntWidth:0] w_bal_q, w_bal_d;
  logic err_q, err_d;

  logic aw_en, w_en, ar_en;
  logic aw_hs, wl_hs, b_hs, ar_hs, rl_hs;
  logic wr_room, rd_room;
  logic bal_neg, bal_pos, drained;

  assign wr_room = wr_cnt_q < CntMax;
  assign rd_room = rd_cnt_q < CntMax;
  assign bal_neg = w_bal_q[CntWidth];
  assign bal_pos = !w_bal_q[CntWidth] && (w_bal_q != '0);
  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0)
                && (w_bal_q == '0);

  assign bus.mst_aw_valid_o = bus.slv_aw_valid_i & aw_en;
  assign bus.slv_aw_ready_o = bus.mst_aw_ready_i & aw_en;
  assign bus.mst_w_valid_o  = bus.slv_w_valid_i & w_en;
  assign bus.slv_w_ready_o  = bus.mst_w_ready_i & w_en;
  assign bus.mst_ar_valid_o = bus.slv_ar_valid_i & ar_en;
  assign bus.slv_ar_ready_o = bus.mst_ar_ready_i & ar_en;

  assign aw_hs = bus.mst_aw_valid_o & bus.mst_aw_ready_i;
  assign wl_hs = bus.mst_w_valid_o & bus.mst_w_ready_i
               & bus.slv_w_last_i;
  assign b_hs  = bus.mst_b_valid_i & bus.mst_b_ready_i;
  assign ar_hs = bus.mst_ar_valid_o & bus.mst_ar_ready_i;
  assign rl_hs = bus.mst_r_valid_i & bus.mst_r_ready_i
               & bus.mst_r_last_i;

  assign isolated_o       = (state_q == StIsolated);
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign proto_err_o      = err_q;

  // Gate enables and next state from registered state only
  always_comb begin
    state_d = state_q;
    aw_en   = 1'b0;
    w_en    = 1'b0;
    ar_en   = 1'b0;
    unique case (state_q)
      StRun: begin
        aw_en = wr_room;
        ar_en = rd_room;
        w_en  = 1'b1;
        if (isolate_req_i) state_d = StDrain;
      end
      StDrain: begin
        aw_en = bal_neg && wr_room;
        w_en  = bal_pos;
        if (!isolate_req_i) state_d = StRun;
        else if (drained)   state_d = StIsolated;
      end
      StIsolated: begin
        if (!isolate_req_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Outstanding counters, W balance and sticky underflow flag
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    w_bal_d  = w_bal_q;
    err_d    = err_q;
    unique case ({aw_hs, b_hs})
      2'b10: wr_cnt_d = wr_cnt_q + CntOne;
      2'b01: begin
        if (wr_cnt_q == '0) err_d = 1'b1;
        else                wr_cnt_d = wr_cnt_q - CntOne;
      end
      default: ;
    endcase
    unique case ({ar_hs, rl_hs})
      2'b10: rd_cnt_d = rd_cnt_q + CntOne;
      2'b01: begin
        if (rd_cnt_q == '0) err_d = 1'b1;
        else                rd_cnt_d = rd_cnt_q - CntOne;
      end
      default: ;
    endcase
    unique case ({aw_hs, wl_hs})
      2'b10:   w_bal_d = w_bal_q + BalOne;
      2'b01:   w_bal_d = w_bal_q - BalOne;
      default: ;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StRun;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_bal_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      w_bal_q  <= w_bal_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_cdc_drain_ctrl.sv
// Bench for axi_cdc_drain_ctrl: two instances (MaxTxns 16 and 2)
// share stimulus and are compared every cycle to a reference model.
module tb_axi_cdc_drain_ctrl;
  localparam int NI      = 2;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_ISO   = 2;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       iso_req = 1'b0;
  logic       iso0, iso1, perr0, perr1;
  logic [4:0] wr0, rd0;
  logic [1:0] wr1, rd1;

  int n_chk = 0;
  int n_err = 0;

  int m_mode[NI];
  int m_wr[NI];
  int m_rd[NI];
  int m_wb[NI];
  bit m_err[NI];
  int m_max[NI] = '{16, 2};

  axi_cdc_drain_ctrl_if bus ();
  axi_cdc_drain_ctrl_if bus2 ();

  assign bus2.slv_aw_valid_i = bus.slv_aw_valid_i;
  assign bus2.mst_aw_ready_i = bus.mst_aw_ready_i;
  assign bus2.slv_w_valid_i  = bus.slv_w_valid_i;
  assign bus2.slv_w_last_i   = bus.slv_w_last_i;
  assign bus2.mst_w_ready_i  = bus.mst_w_ready_i;
  assign bus2.slv_ar_valid_i = bus.slv_ar_valid_i;
  assign bus2.mst_ar_ready_i = bus.mst_ar_ready_i;
  assign bus2.mst_b_valid_i  = bus.mst_b_valid_i;
  assign bus2.mst_b_ready_i  = bus.mst_b_ready_i;
  assign bus2.mst_r_valid_i  = bus.mst_r_valid_i;
  assign bus2.mst_r_ready_i  = bus.mst_r_ready_i;
  assign bus2.mst_r_last_i   = bus.mst_r_last_i;

  always #5 clk = ~clk;

  axi_cdc_drain_ctrl #(.MaxTxns(16)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .isolate_req_i    (iso_req),
    .isolated_o       (iso0),
    .bus              (bus),
    .wr_outstanding_o (wr0),
    .rd_outstanding_o (rd0),
    .proto_err_o      (perr0)
  );

  axi_cdc_drain_ctrl #(.MaxTxns(2)) u_sat (
    .clk_i            (clk),
    .rst_i            (rst),
    .isolate_req_i    (iso_req),
    .isolated_o       (iso1),
    .bus              (bus2),
    .wr_outstanding_o (wr1),
    .rd_outstanding_o (rd1),
    .proto_err_o      (perr1)
  );

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      m_mode[k] = M_RUN;
      m_wr[k]   = 0;
      m_rd[k]   = 0;
      m_wb[k]   = 0;
      m_err[k]  = 1'b0;
    end
  endfunction

  function automatic bit aw_ok(int k);
    return m_wr[k] < m_max[k] && (m_mode[k] == M_RUN ||
           (m_mode[k] == M_DRAIN && m_wb[k] < 0));
  endfunction

  function automatic bit w_ok(int k);
    return m_mode[k] == M_RUN || (m_mode[k] == M_DRAIN && m_wb[k] > 0);
  endfunction

  function automatic bit ar_ok(int k);
    return m_rd[k] < m_max[k] && m_mode[k] == M_RUN;
  endfunction

  function automatic logic [17:0] exp_v(int k);
    return {bus.slv_aw_valid_i & aw_ok(k), bus.mst_aw_ready_i & aw_ok(k),
            bus.slv_w_valid_i & w_ok(k), bus.mst_w_ready_i & w_ok(k),
            bus.slv_ar_valid_i & ar_ok(k), bus.mst_ar_ready_i & ar_ok(k),
            (m_mode[k] == M_ISO), m_err[k], 5'(m_wr[k]), 5'(m_rd[k])};
  endfunction

  function automatic logic [17:0] obs_v(int k);
    if (k == 0)
      return {bus.mst_aw_valid_o, bus.slv_aw_ready_o,
              bus.mst_w_valid_o, bus.slv_w_ready_o,
              bus.mst_ar_valid_o, bus.slv_ar_ready_o,
              iso0, perr0, wr0, rd0};
    return {bus2.mst_aw_valid_o, bus2.slv_aw_ready_o,
            bus2.mst_w_valid_o, bus2.slv_w_ready_o,
            bus2.mst_ar_valid_o, bus2.slv_ar_ready_o,
            iso1, perr1, 3'b000, wr1, 3'b000, rd1};
  endfunction

  task automatic chk(string tag, logic [17:0] obs, logic [17:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.slv_aw_valid_i = 1'b0;
    bus.mst_aw_ready_i = 1'b0;
    bus.slv_w_valid_i  = 1'b0;
    bus.slv_w_last_i   = 1'b0;
    bus.mst_w_ready_i  = 1'b0;
    bus.slv_ar_valid_i = 1'b0;
    bus.mst_ar_ready_i = 1'b0;
    bus.mst_b_valid_i  = 1'b0;
    bus.mst_b_ready_i  = 1'b0;
    bus.mst_r_valid_i  = 1'b0;
    bus.mst_r_ready_i  = 1'b0;
    bus.mst_r_last_i   = 1'b0;
  endtask

  // one clock: compare both instances to the model, then advance it
  task automatic cyc();
    bit aw[NI];
    bit wl[NI];
    bit ar[NI];
    bit b, rl;
    int nm;
    string tag;
    #1;
    for (int k = 0; k < NI; k++) begin
      if (k == 0) tag = "model_main";
      else        tag = "model_sat";
      chk(tag, obs_v(k), exp_v(k));
      aw[k] = bus.slv_aw_valid_i && bus.mst_aw_ready_i && aw_ok(k);
      wl[k] = bus.slv_w_valid_i && bus.mst_w_ready_i &&
              bus.slv_w_last_i && w_ok(k);
      ar[k] = bus.slv_ar_valid_i && bus.mst_ar_ready_i && ar_ok(k);
    end
    b  = bus.mst_b_valid_i && bus.mst_b_ready_i;
    rl = bus.mst_r_valid_i && bus.mst_r_ready_i && bus.mst_r_last_i;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        nm = m_mode[k];
        if (m_mode[k] == M_RUN && iso_req) nm = M_DRAIN;
        else if (m_mode[k] == M_DRAIN) begin
          if (!iso_req) nm = M_RUN;
          else if (m_wr[k] == 0 && m_rd[k] == 0 && m_wb[k] == 0)
            nm = M_ISO;
        end else if (m_mode[k] == M_ISO && !iso_req) nm = M_RUN;
        m_mode[k] = nm;
        m_wr[k] += int'(aw[k]) - int'(b);
        if (m_wr[k] < 0) begin
          m_wr[k]  = 0;
          m_err[k] = 1'b1;
        end
        m_rd[k] += int'(ar[k]) - int'(rl);
        if (m_rd[k] < 0) begin
          m_rd[k]  = 0;
          m_err[k] = 1'b1;
        end
        m_wb[k] += int'(aw[k]) - int'(wl[k]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    bit b_ok, r_ok, w_ok_all;
    b_ok = 1'b1;
    r_ok = 1'b1;
    w_ok_all = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (!(m_wr[k] > 0 && m_wr[k] > m_wb[k])) b_ok = 1'b0;
      if (m_rd[k] == 0) r_ok = 1'b0;
      if (m_wb[k] <= -2) w_ok_all = 1'b0;
    end
    bus.slv_aw_valid_i = 1'($urandom_range(0, 1));
    bus.mst_aw_ready_i = 1'($urandom_range(0, 1));
    bus.slv_w_valid_i  = w_ok_all && 1'($urandom_range(0, 1));
    bus.slv_w_last_i   = 1'($urandom_range(0, 1));
    bus.mst_w_ready_i  = 1'($urandom_range(0, 1));
    bus.slv_ar_valid_i = 1'($urandom_range(0, 1));
    bus.mst_ar_ready_i = 1'($urandom_range(0, 1));
    bus.mst_b_valid_i  = b_ok && 1'($urandom_range(0, 1));
    bus.mst_b_ready_i  = 1'($urandom_range(0, 1));
    bus.mst_r_valid_i  = r_ok && 1'($urandom_range(0, 1));
    bus.mst_r_ready_i  = 1'($urandom_range(0, 1));
    bus.mst_r_last_i   = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 19) == 0) iso_req = ~iso_req;
    rst = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    m_reset();
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // reset state and valid pass-through
    chk("rst_state", 18'({iso0, perr0, wr0, rd0}), 18'd0);
    bus.slv_aw_valid_i = 1'b1;
    bus.slv_w_valid_i  = 1'b1;
    bus.slv_ar_valid_i = 1'b1;
    #1;
    chk("pass_valid", 18'({bus.mst_aw_valid_o, bus.mst_w_valid_o,
                           bus.mst_ar_valid_o}), 18'd7);
    idle();
    bus.slv_aw_valid_i = 1'b1;
    bus.mst_aw_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("wr_up", 18'(wr0), 18'(i));
    end
    idle();
    bus.slv_w_valid_i = 1'b1;
    bus.slv_w_last_i  = 1'b1;
    bus.mst_w_ready_i = 1'b1;
    repeat (3) cyc();
    idle();
    bus.mst_b_valid_i = 1'b1;
    bus.mst_b_ready_i = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      cyc();
      chk("wr_down", 18'(wr0), 18'(i));
    end

    // drain with two writes owed
    do_reset();
    bus.slv_aw_valid_i = 1'b1;
    bus.mst_aw_ready_i = 1'b1;
    repeat (2) cyc();
    idle();
    iso_req = 1'b1;
    cyc();
    bus.slv_aw_valid_i = 1'b1;
    bus.mst_aw_ready_i = 1'b1;
    bus.slv_ar_valid_i = 1'b1;
    bus.mst_ar_ready_i = 1'b1;
    bus.slv_w_valid_i  = 1'b1;
    bus.slv_w_last_i   = 1'b1;
    bus.mst_w_ready_i  = 1'b1;
    #1;
    chk("drain_hold", 18'({bus.slv_aw_ready_o, bus.mst_aw_valid_o,
                           bus.slv_ar_ready_o, bus.mst_ar_valid_o,
                           bus.mst_w_valid_o, bus.slv_w_ready_o}),
        18'b000011);
    repeat (2) cyc();
    chk("drain_w_closed", 18'(bus.mst_w_valid_o), 18'd0);
    bus.mst_b_valid_i = 1'b1;
    bus.mst_b_ready_i = 1'b1;
    repeat (2) cyc();
    bus.mst_b_valid_i = 1'b0;
    chk("wr0_not_iso", 18'({wr0, iso0}), 18'd0);
    cyc();
    chk("iso_set", 18'(iso0), 18'd1);
    idle();
    iso_req = 1'b0;
    cyc();
    chk("iso_drop", 18'(iso0), 18'd0);

    // W leads AW, matching AW admitted while draining
    do_reset();
    bus.slv_w_valid_i = 1'b1;
    bus.slv_w_last_i  = 1'b1;
    bus.mst_w_ready_i = 1'b1;
    cyc();
    idle();
    iso_req = 1'b1;
    cyc();
    bus.slv_aw_valid_i = 1'b1;
    bus.mst_aw_ready_i = 1'b1;
    #1;
    chk("aw_matched", 18'(bus.slv_aw_ready_o), 18'd1);
    cyc();
    chk("aw_unmatched", 18'(bus.slv_aw_ready_o), 18'd0);
    bus.mst_b_valid_i = 1'b1;
    bus.mst_b_ready_i = 1'b1;
    cyc();
    bus.mst_b_valid_i = 1'b0;
    cyc();
    chk("lead_iso", 18'({iso0, bus.mst_aw_valid_o}), 18'b10);
    idle();
    iso_req = 1'b0;
    cyc();

    // AR saturation on the MaxTxns=2 instance
    do_reset();
    bus.slv_ar_valid_i = 1'b1;
    bus.mst_ar_ready_i = 1'b1;
    repeat (2) cyc();
    chk("sat_stall", 18'({bus2.slv_ar_ready_o, bus2.mst_ar_valid_o,
                          bus.slv_ar_ready_o}), 18'b001);
    cyc();
    bus.mst_r_valid_i = 1'b1;
    bus.mst_r_ready_i = 1'b1;
    bus.mst_r_last_i  = 1'b1;
    #1;
    chk("sat_stall_r", 18'(bus2.slv_ar_ready_o), 18'd0);
    cyc();
    bus.mst_r_valid_i = 1'b0;
    #1;
    chk("sat_accept", 18'(bus2.slv_ar_ready_o), 18'd1);
    cyc();
    chk("sat_rd", 18'({rd1, rd0}), 18'({2'd2, 5'd4}));
    idle();

    // simultaneous AW/B and B underflow
    do_reset();
    bus.slv_aw_valid_i = 1'b1;
    bus.mst_aw_ready_i = 1'b1;
    cyc();
    bus.mst_b_valid_i = 1'b1;
    bus.mst_b_ready_i = 1'b1;
    cyc();
    chk("aw_b_same", 18'({wr0, perr0}), 18'({5'd1, 1'b0}));
    bus.slv_aw_valid_i = 1'b0;
    cyc();
    cyc();
    chk("b_underflow", 18'({wr0, perr0}), 18'({5'd0, 1'b1}));
    idle();

    // reset in the middle of a drain
    do_reset();
    bus.slv_ar_valid_i = 1'b1;
    bus.mst_ar_ready_i = 1'b1;
    repeat (2) cyc();
    idle();
    iso_req = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.slv_ar_valid_i = 1'b1;
    bus.mst_ar_ready_i = 1'b1;
    #1;
    chk("rst_drain", 18'({rd0, wr0, bus.slv_ar_ready_o, iso0}),
        18'b0000000000_1_0);
    idle();
    repeat (2) cyc();
    chk("iso_again", 18'(iso0), 18'd1);
    iso_req = 1'b0;
    cyc();
    chk("iso_release", 18'(iso0), 18'd0);

    // randomized traffic against the model
    do_reset();
    repeat (800) begin
      rand_inputs();
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
